// File: rtl/demux_stream.sv
// One-to-N stream demultiplexer with a one-entry output register per channel.
// Supports unicast by select index, optional broadcast, and counts beats whose select is out of range.
module demux_stream #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned N_OUT    = 4,
    parameter int unsigned SEL_W    = 2,
    parameter bit          BCAST_EN = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_bcast,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic [N_OUT-1:0]        out_valid,
    input  logic [N_OUT-1:0]        out_ready,
    output logic [7:0]              err_cnt
);

    logic [N_OUT-1:0]        vld_q, vld_d;
    logic [N_OUT*DATA_W-1:0] data_q, data_d;
    logic [7:0]              err_q, err_d;

    logic [N_OUT-1:0] can_load;
    logic [N_OUT-1:0] sel_hit;
    logic             bcast;
    logic             sel_ok;
    logic             xfer;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign bcast    = BCAST_EN && in_bcast;
    assign can_load = ~vld_q | out_ready;

    // sel_hit is all-zero when in_sel names a channel that does not exist
    always_comb begin
        sel_hit = '0;
        for (int k = 0; k < N_OUT; k++) begin
            sel_hit[k] = (in_sel == SEL_W'(k));
        end
    end

    assign sel_ok = |sel_hit;

    always_comb begin
        in_ready = 1'b1;
        if (bcast) begin
            in_ready = &can_load;
        end else if (sel_ok) begin
            in_ready = |(sel_hit & can_load);
        end
    end

    assign xfer = in_valid && in_ready;

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        err_d  = err_q;
        for (int k = 0; k < N_OUT; k++) begin
            if (xfer && (bcast || sel_hit[k])) begin
                vld_d[k]                   = 1'b1;
                data_d[k*DATA_W +: DATA_W] = in_data;
            end else if (out_ready[k]) begin
                vld_d[k] = 1'b0;
            end
        end
        if (xfer && !bcast && !sel_ok) begin
            err_d = sat_inc(err_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            data_q <= '0;
            err_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
            err_q  <= err_d;
        end
    end

    assign out_valid = vld_q;
    assign out_data  = data_q;
    assign err_cnt   = err_q;

endmodule

// File: tb/tb_demux_stream.sv
// Directed bench for demux_stream: a 4-channel instance for unicast/broadcast/backpressure
// and a 3-channel instance for out-of-range selects and error-counter saturation.
module tb_demux_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic [7:0]  in_data   = '0;
    logic [1:0]  in_sel    = '0;
    logic        in_bcast  = 1'b0;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready = '0;
    logic [7:0]  err_cnt;

    logic [7:0]  d3_in_data   = '0;
    logic [1:0]  d3_in_sel    = '0;
    logic        d3_in_bcast  = 1'b0;
    logic        d3_in_valid  = 1'b0;
    logic        d3_in_ready;
    logic [23:0] d3_out_data;
    logic [2:0]  d3_out_valid;
    logic [2:0]  d3_out_ready = '0;
    logic [7:0]  d3_err_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    demux_stream #(.DATA_W(8), .N_OUT(4), .SEL_W(2), .BCAST_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .err_cnt(err_cnt)
    );

    demux_stream #(.DATA_W(8), .N_OUT(3), .SEL_W(2), .BCAST_EN(1'b1)) dut3 (
        .clk(clk), .rst(rst),
        .in_data(d3_in_data), .in_sel(d3_in_sel), .in_bcast(d3_in_bcast),
        .in_valid(d3_in_valid), .in_ready(d3_in_ready),
        .out_data(d3_out_data), .out_valid(d3_out_valid), .out_ready(d3_out_ready),
        .err_cnt(d3_err_cnt)
    );

    typedef struct {
        logic        v;
        logic [1:0]  sel;
        logic        b;
        logic [7:0]  d;
        logic [3:0]  ordy;
        logic        rdy;
        logic [3:0]  ov;
        logic [31:0] od;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic step4(input logic v, input logic [1:0] s, input logic b,
                         input logic [7:0] d, input logic [3:0] r);
        @(negedge clk);
        in_valid = v; in_sel = s; in_bcast = b; in_data = d; out_ready = r;
        #1;
    endtask

    task automatic step3(input logic v, input logic [1:0] s, input logic [7:0] d,
                         input logic [2:0] r);
        @(negedge clk);
        d3_in_valid = v; d3_in_sel = s; d3_in_bcast = 1'b0; d3_in_data = d; d3_out_ready = r;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, limit 200000 time units");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1'b1, 2'd0, 1'b0, 8'hA0, 4'hF, 1'b1, 4'b0001, 32'h000000A0};
        tbl[1]  = '{1'b1, 2'd1, 1'b0, 8'hA1, 4'hF, 1'b1, 4'b0010, 32'h0000A1A0};
        tbl[2]  = '{1'b1, 2'd2, 1'b0, 8'hA2, 4'hF, 1'b1, 4'b0100, 32'h00A2A1A0};
        tbl[3]  = '{1'b1, 2'd3, 1'b0, 8'hA3, 4'hF, 1'b1, 4'b1000, 32'hA3A2A1A0};
        tbl[4]  = '{1'b0, 2'd0, 1'b0, 8'h00, 4'hF, 1'b1, 4'b0000, 32'hA3A2A1A0};
        tbl[5]  = '{1'b1, 2'd2, 1'b1, 8'h5A, 4'hF, 1'b1, 4'b1111, 32'h5A5A5A5A};
        tbl[6]  = '{1'b1, 2'd0, 1'b1, 8'h77, 4'hD, 1'b0, 4'b0010, 32'h5A5A5A5A};
        tbl[7]  = '{1'b1, 2'd3, 1'b1, 8'h77, 4'hD, 1'b0, 4'b0010, 32'h5A5A5A5A};
        tbl[8]  = '{1'b1, 2'd1, 1'b1, 8'h77, 4'hF, 1'b1, 4'b1111, 32'h77777777};
        tbl[9]  = '{1'b0, 2'd0, 1'b0, 8'h00, 4'hF, 1'b1, 4'b0000, 32'h77777777};
        tbl[10] = '{1'b1, 2'd0, 1'b0, 8'h01, 4'h0, 1'b1, 4'b0001, 32'h77777701};
        tbl[11] = '{1'b1, 2'd0, 1'b0, 8'h02, 4'h0, 1'b0, 4'b0001, 32'h77777701};
        tbl[12] = '{1'b1, 2'd1, 1'b0, 8'h03, 4'h0, 1'b1, 4'b0011, 32'h77770301};
        tbl[13] = '{1'b1, 2'd0, 1'b0, 8'h04, 4'h1, 1'b1, 4'b0011, 32'h77770304};
        tbl[14] = '{1'b0, 2'd0, 1'b0, 8'h00, 4'hF, 1'b1, 4'b0000, 32'h77770304};

        // reset state, checked before any clock edge
        #1 rst = 1'b1;
        #1;
        chk("rst out_valid", 32'(out_valid), 32'h0);
        chk("rst out_data", out_data, 32'h0);
        chk("rst err_cnt", 32'(err_cnt), 32'h0);
        chk("rst d3 out_valid", 32'(d3_out_valid), 32'h0);
        chk("rst d3 err_cnt", 32'(d3_err_cnt), 32'h0);

        // beat offered during reset is not stored
        step4(1'b1, 2'd0, 1'b0, 8'hEE, 4'h0);
        chk("rst in_ready", 32'(in_ready), 32'h1);
        tick();
        chk("rst beat dropped", 32'(out_valid), 32'h0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            step4(tbl[i].v, tbl[i].sel, tbl[i].b, tbl[i].d, tbl[i].ordy);
            chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
            tick();
            chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
            chk($sformatf("vec%0d out_data", i), out_data, tbl[i].od);
        end

        // backpressure on channel 2
        step4(1'b1, 2'd2, 1'b0, 8'h11, 4'b1011);
        chk("bp first in_ready", 32'(in_ready), 32'h1);
        tick();
        chk("bp first valid", 32'(out_valid), 32'h4);
        chk("bp first lane2", 32'(out_data[23:16]), 32'h11);
        for (int i = 0; i < 2; i++) begin
            step4(1'b1, 2'd2, 1'b0, 8'h22, 4'b1011);
            chk($sformatf("bp stall%0d in_ready", i), 32'(in_ready), 32'h0);
            tick();
            chk($sformatf("bp stall%0d valid", i), 32'(out_valid), 32'h4);
            chk($sformatf("bp stall%0d lane2", i), 32'(out_data[23:16]), 32'h11);
        end
        step4(1'b1, 2'd2, 1'b0, 8'h22, 4'b1111);
        chk("bp release in_ready", 32'(in_ready), 32'h1);
        tick();
        chk("bp release valid", 32'(out_valid), 32'h4);
        chk("bp release lane2", 32'(out_data[23:16]), 32'h22);
        step4(1'b0, 2'd0, 1'b0, 8'h00, 4'b1111);
        tick();
        chk("bp drain valid", 32'(out_valid), 32'h0);

        // fill everything, then reset asynchronously between edges
        step4(1'b1, 2'd0, 1'b1, 8'hC3, 4'h0);
        tick();
        chk("fill valid", 32'(out_valid), 32'hF);
        step4(1'b0, 2'd0, 1'b0, 8'h00, 4'h0);
        for (int i = 0; i < 5; i++) begin
            step3(1'b1, 2'd3, 8'(i), 3'b000);
            tick();
        end
        step3(1'b1, 2'd0, 8'h9C, 3'b000);
        tick();
        chk("d3 err before reset", 32'(d3_err_cnt), 32'd5);
        chk("d3 valid before reset", 32'(d3_out_valid), 32'h1);
        step3(1'b0, 2'd0, 8'h00, 3'b000);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async rst out_valid", 32'(out_valid), 32'h0);
        chk("async rst out_data", out_data, 32'h0);
        chk("async rst d3 out_valid", 32'(d3_out_valid), 32'h0);
        chk("async rst d3 out_data", 32'(d3_out_data), 32'h0);
        chk("async rst d3 err_cnt", 32'(d3_err_cnt), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step4(1'b1, 2'd0, 1'b0, 8'h33, 4'hF);
        chk("post rst in_ready", 32'(in_ready), 32'h1);
        tick();
        chk("post rst valid", 32'(out_valid), 32'h1);
        chk("post rst data", out_data, 32'h00000033);
        step4(1'b0, 2'd0, 1'b0, 8'h00, 4'hF);

        // out-of-range select on the 3-channel instance
        step3(1'b1, 2'd0, 8'h9C, 3'b000);
        tick();
        for (int i = 0; i < 300; i++) begin
            step3(1'b1, 2'd3, 8'(i), 3'b000);
            chk($sformatf("badsel%0d in_ready", i), 32'(d3_in_ready), 32'h1);
            tick();
            if (i == 253) chk("err_cnt at 254 beats", 32'(d3_err_cnt), 32'd254);
            if (i == 254) chk("err_cnt at 255 beats", 32'(d3_err_cnt), 32'd255);
        end
        chk("err_cnt saturated", 32'(d3_err_cnt), 32'd255);
        chk("badsel valid held", 32'(d3_out_valid), 32'h1);
        chk("badsel data held", 32'(d3_out_data), 32'h00009C);
        step3(1'b0, 2'd0, 8'h00, 3'b000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
